execute_mc: RTL
===============

Name: execute_mc

Overview:
Parametrised multi-cycle successor to the single-cycle execute stage. It sits between decode and the register file and data memory, and accepts one decoded instruction at a time through a valid/ready handshake. It adds an iterative multiplier (MUL/MULS), a variable-latency memory handshake, and the full NZCV branch-condition set.

Parameters:
DATA_W, 32, datapath, register and memory-address width (16..64, even)
IMM_W, 16, immediate width; sign-extended to DATA_W
REG_AW, 4, register-index width
MUL_STEP, 1, multiplier bits retired per cycle (1, 2 or 4; must divide DATA_W)

Ports:
clk  in  1  clock
rst  in  1  reset: asynchronous assert, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  block can accept an instruction
firstLevelDecode  in  2  00 ALU-imm/MOV, 01 ALU-reg, 10 mem, 11 branch
specialEncoding  in  1  00x: 0 = MOV group, 1 = ALU-imm
secondLevelDecode  in  4  0000 MUL, 0001 ADD, 0010 SUB, 1000 MULS, 1001 ADDS, 1010 SUBS
aluFunctions  in  3  MOV group: 000 MOV, 010 CLR; mem: bit0 1 = store
branchInstruction  in  4  condition code (see Behaviour)
imm  in  IMM_W  immediate / branch offset
destReg, sourceFirstReg, sourceSecReg  in  REG_AW  register indices
readRegDest, readRegFirst, readRegSec  out  REG_AW  read addresses, combinational pass-through of the index inputs
readDataDest, readDataFirst, readDataSec  in  DATA_W  register read data, sampled at accept
wb_valid  out  1  one-cycle write-back strobe
wb_reg  out  REG_AW  write-back index
wb_data  out  DATA_W  write-back data
branch_taken  out  1  one-cycle pulse, cycle after accept
exeData  out  IMM_W  branch offset, registered with branch_taken
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  DATA_W  byte address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  request completes this cycle
mem_rdata  in  DATA_W  load data, valid with mem_ack
flags  out  4  NZCV register

Behaviour:
- Reset: state IDLE; in_ready=1 after reset; all other outputs, flags and internal registers are 0. Reset mid-MUL or mid-memory aborts immediately: mem_req drops, no write-back, flags cleared.
- Accept: in_valid & in_ready. in_ready=1 only in IDLE. Operands and imm are latched at accept.
- States: IDLE, MUL, MEM.
- IDLE → IDLE for single-cycle ops:
  - MOV/CLR/ADD/SUB/ADDS/SUBS (imm or reg) and branches.
  - wb_valid pulses the cycle after accept; back-to-back accepts are allowed.
- ADD/SUB use DATA_W+1-bit arithmetic; the result is truncated.
- S-variant flags:
  - N = result MSB; Z = (result == 0).
  - ADDS: C = carry out; V = same-sign operands with a different-sign result.
  - SUBS: C = NOT borrow; V = different-sign operands with result sign ≠ first operand sign.
  - Flags update on the clock edge after accept.
- MOV writes sign-extended imm. CLR writes 0.
- IDLE → MUL on MUL/MULS:
  - Sub-module runs DATA_W/MUL_STEP cycles.
  - wb_valid in the cycle after the last step; then IDLE.
  - Result is the low DATA_W bits of the unsigned product (the same low bits as a signed product).
  - MULS sets N and Z; C and V are unchanged.
  - MUL-imm uses the sign-extended imm as the second operand.
- IDLE → MEM on load/store:
  - mem_addr = readDataFirst + sext(imm), modulo 2^DATA_W.
  - Store data = readDataDest.
  - mem_req is asserted the cycle after accept; mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack.
  - On mem_ack: mem_req drops the next cycle, state returns to IDLE.
  - Load: wb_valid with wb_data = mem_rdata, registered, the cycle after mem_ack.
  - A mem_ack in the same cycle mem_req first rises is legal. A mem_ack seen in IDLE is ignored.
- Branch conditions: evaluated on the current flags at accept. Flags are never pending at accept, because in_ready is low while a MUL or memory op is in flight.
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never
- Undefined encodings: accepted as NOP. No write-back, flags unchanged.

Decomposition:
- Package exec_pkg: state enum (IDLE/MUL/MEM); firstLevelDecode, secondLevelDecode and aluFunctions constants; branch condition codes; flag bit positions (N=3, Z=2, C=1, V=0); a cond_pass function.
- One sub-module, exec_mul_iter, parametrised by DATA_W and MUL_STEP, with start/done handshake and shift-add iteration.

Test Plan:
- rst high mid-MUL (step 5) → next cycle in_ready=1, wb_valid=0, flags=0000, mem_req=0.
- SUBS r1=5, imm=5 → flags=0110 (Z,C); then BEQ → branch_taken=1; BNE → 0; BLS → 1.
- ADDS 0x7FFFFFFF + 1 (DATA_W=32) → wb_data=0x80000000, flags=1001; BLT → not taken (N==V); BGE → taken.
- MUL r1=0xFFFFFFFF, r2=3, MUL_STEP=1 → in_ready low for 32 cycles, wb_data=0xFFFFFFFD on cycle 33; repeat with MUL_STEP=4 → wb on cycle 9.
- Load base=0x100, imm=-4, mem_ack delayed 3 cycles → mem_addr=0xFC held stable for 3 cycles, wb_valid one cycle after ack with mem_rdata; store with ack in the first cycle → no wb_valid, in_ready back after 2 cycles.
- Back-to-back ADD, ADD, MOV imm=0x8000 with in_valid held high → three consecutive wb_valid pulses; MOV writes 0xFFFF8000.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared decode constants, state encoding and branch-condition helper
// for the multi-cycle execute stage.
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        MEM  = 2'd2
    } state_e;

    localparam logic [1:0] FLD_ALU_IMM = 2'b00;
    localparam logic [1:0] FLD_ALU_REG = 2'b01;
    localparam logic [1:0] FLD_MEM     = 2'b10;
    localparam logic [1:0] FLD_BRANCH  = 2'b11;

    localparam logic [3:0] OP_MUL  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MULS = 4'b1000;
    localparam logic [3:0] OP_ADDS = 4'b1001;
    localparam logic [3:0] OP_SUBS = 4'b1010;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_CLR = 3'b010;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    // Evaluate a branch condition code against the NZCV register.
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, p;
        n = f[F_N];
        z = f[F_Z];
        c = f[F_C];
        v = f[F_V];
        p = 1'b0;
        unique case (cc)
            CC_EQ: p = z;
            CC_NE: p = !z;
            CC_CS: p = c;
            CC_CC: p = !c;
            CC_MI: p = n;
            CC_PL: p = !n;
            CC_VS: p = v;
            CC_VC: p = !v;
            CC_HI: p = c && !z;
            CC_LS: p = !c || z;
            CC_GE: p = (n == v);
            CC_LT: p = (n != v);
            CC_GT: p = !z && (n == v);
            CC_LE: p = z || (n != v);
            CC_AL: p = 1'b1;
            CC_NV: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle;
// produces the low DATA_W bits of the product.
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int STEPS = DATA_W / MUL_STEP;
    localparam int CW    = $clog2(STEPS + 1);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [CW-1:0]     cnt_q;

    // Accumulate the shifted multiplicand for each set multiplier bit of this step.
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (mplier_q[k]) acc_d = acc_d + (mcand_q << k);
        end
    end

    // The final step's sum is forwarded combinationally so the caller can register it.
    assign done_o   = (cnt_q == CW'(1));
    assign result_o = acc_d;

    // Operand load on start, then one shift-add step per cycle while counting down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CW'(STEPS);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: single-cycle ALU/branch ops, iterative multiply
// and a variable-latency load/store handshake, with an NZCV flag register.
module execute_mc
    import exec_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 16,
    parameter int REG_AW   = 4,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        firstLevelDecode,
    input  logic              specialEncoding,
    input  logic [3:0]        secondLevelDecode,
    input  logic [2:0]        aluFunctions,
    input  logic [3:0]        branchInstruction,
    input  logic [IMM_W-1:0]  imm,
    input  logic [REG_AW-1:0] destReg,
    input  logic [REG_AW-1:0] sourceFirstReg,
    input  logic [REG_AW-1:0] sourceSecReg,
    output logic [REG_AW-1:0] readRegDest,
    output logic [REG_AW-1:0] readRegFirst,
    output logic [REG_AW-1:0] readRegSec,
    input  logic [DATA_W-1:0] readDataDest,
    input  logic [DATA_W-1:0] readDataFirst,
    input  logic [DATA_W-1:0] readDataSec,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              branch_taken,
    output logic [IMM_W-1:0]  exeData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        flags
);

    localparam int MSB = DATA_W - 1;

    state_e            state_q, state_d;
    logic              wbv_q, wbv_d;
    logic [REG_AW-1:0] wbr_q, wbr_d;
    logic [DATA_W-1:0] wbd_q, wbd_d;
    logic              br_q, br_d;
    logic [IMM_W-1:0]  exe_q, exe_d;
    logic              mreq_q, mreq_d;
    logic              mwe_q, mwe_d;
    logic [DATA_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [3:0]        flags_q, flags_d;
    logic [REG_AW-1:0] mdst_q, mdst_d;
    logic              muls_q, muls_d;

    logic [DATA_W-1:0] simm, opa, opb;
    logic [DATA_W:0]   add_w, sub_w;
    logic [3:0]        add_f, sub_f;
    logic              is_mov, is_alu, is_mem, is_br;
    logic              mul_start, mul_done;
    logic [DATA_W-1:0] mul_res;

    assign readRegDest  = destReg;
    assign readRegFirst = sourceFirstReg;
    assign readRegSec   = sourceSecReg;

    assign simm  = DATA_W'($signed(imm));
    assign opa   = readDataFirst;
    assign opb   = (firstLevelDecode == FLD_ALU_REG) ? readDataSec : simm;
    assign add_w = {1'b0, opa} + {1'b0, opb};
    assign sub_w = {1'b0, opa} - {1'b0, opb};

    assign add_f = {add_w[MSB], add_w[MSB:0] == '0, add_w[DATA_W],
                    (opa[MSB] == opb[MSB]) && (add_w[MSB] != opa[MSB])};
    assign sub_f = {sub_w[MSB], sub_w[MSB:0] == '0, !sub_w[DATA_W],
                    (opa[MSB] != opb[MSB]) && (sub_w[MSB] != opa[MSB])};

    assign is_mov = (firstLevelDecode == FLD_ALU_IMM) && !specialEncoding;
    assign is_alu = ((firstLevelDecode == FLD_ALU_IMM) && specialEncoding)
                  || (firstLevelDecode == FLD_ALU_REG);
    assign is_mem = (firstLevelDecode == FLD_MEM);
    assign is_br  = (firstLevelDecode == FLD_BRANCH);

    exec_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (opa),
        .b_i      (opb),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    // Next-state, decode at accept, and completion of multi-cycle operations.
    always_comb begin
        state_d   = state_q;
        wbv_d     = 1'b0;
        wbr_d     = wbr_q;
        wbd_d     = wbd_q;
        br_d      = 1'b0;
        exe_d     = exe_q;
        mreq_d    = mreq_q;
        mwe_d     = mwe_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        flags_d   = flags_q;
        mdst_d    = mdst_q;
        muls_d    = muls_q;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    unique case (1'b1)
                        is_mov: begin
                            if (aluFunctions == ALU_MOV) begin
                                wbv_d = 1'b1;
                                wbr_d = destReg;
                                wbd_d = simm;
                            end else if (aluFunctions == ALU_CLR) begin
                                wbv_d = 1'b1;
                                wbr_d = destReg;
                                wbd_d = '0;
                            end
                        end
                        is_alu: begin
                            unique case (secondLevelDecode)
                                OP_MUL, OP_MULS: begin
                                    mul_start = 1'b1;
                                    state_d   = MUL;
                                    mdst_d    = destReg;
                                    muls_d    = secondLevelDecode[3];
                                end
                                OP_ADD, OP_ADDS: begin
                                    wbv_d = 1'b1;
                                    wbr_d = destReg;
                                    wbd_d = add_w[MSB:0];
                                    if (secondLevelDecode[3]) flags_d = add_f;
                                end
                                OP_SUB, OP_SUBS: begin
                                    wbv_d = 1'b1;
                                    wbr_d = destReg;
                                    wbd_d = sub_w[MSB:0];
                                    if (secondLevelDecode[3]) flags_d = sub_f;
                                end
                                default: ;
                            endcase
                        end
                        is_mem: begin
                            state_d  = MEM;
                            mreq_d   = 1'b1;
                            mwe_d    = aluFunctions[0];
                            maddr_d  = add_w[MSB:0];
                            mwdata_d = readDataDest;
                            mdst_d   = destReg;
                        end
                        is_br: begin
                            br_d  = cond_pass(branchInstruction, flags_q);
                            exe_d = imm;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = IDLE;
                    wbv_d   = 1'b1;
                    wbr_d   = mdst_q;
                    wbd_d   = mul_res;
                    if (muls_q) begin
                        flags_d[F_N] = mul_res[MSB];
                        flags_d[F_Z] = (mul_res == '0);
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    mreq_d  = 1'b0;
                    if (!mwe_q) begin
                        wbv_d = 1'b1;
                        wbr_d = mdst_q;
                        wbd_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wbv_q    <= 1'b0;
            wbr_q    <= '0;
            wbd_q    <= '0;
            br_q     <= 1'b0;
            exe_q    <= '0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            flags_q  <= '0;
            mdst_q   <= '0;
            muls_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wbv_q    <= wbv_d;
            wbr_q    <= wbr_d;
            wbd_q    <= wbd_d;
            br_q     <= br_d;
            exe_q    <= exe_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            flags_q  <= flags_d;
            mdst_q   <= mdst_d;
            muls_q   <= muls_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign wb_valid     = wbv_q;
    assign wb_reg       = wbr_q;
    assign wb_data      = wbd_q;
    assign branch_taken = br_q;
    assign exeData      = exe_q;
    assign mem_req      = mreq_q;
    assign mem_we       = mwe_q;
    assign mem_addr     = maddr_q;
    assign mem_wdata    = mwdata_q;
    assign flags        = flags_q;

endmodule
